// File: rtl/decode_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_writeback_if
// Purpose  : Bundle of fetch/execute/memory signals seen by the Y86-64
//            decode / write-back stage. The master drives the instruction
//            fields and the write-back data; the slave (the stage) returns
//            the operands, the decoded register IDs and the debug read port.
// Revision : 1.0 - initial release
// ============================================================================
interface decode_writeback_if;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic [3:0]  rA;
   logic [3:0]  rB;
   logic        cnd;
   logic [63:0] valE;
   logic [63:0] valM;
   logic        halt;
   logic [3:0]  dbg_sel;
   logic [63:0] valA;
   logic [63:0] valB;
   logic [3:0]  srcA;
   logic [3:0]  srcB;
   logic [3:0]  dstE;
   logic [3:0]  dstM;
   logic [3:0]  ifun_o;
   logic [63:0] dbg_val;

   modport master (
      output icode, ifun, rA, rB, cnd, valE, valM, halt, dbg_sel,
      input  valA, valB, srcA, srcB, dstE, dstM, ifun_o, dbg_val
   );

   modport slave (
      input  icode, ifun, rA, rB, cnd, valE, valM, halt, dbg_sel,
      output valA, valB, srcA, srcB, dstE, dstM, ifun_o, dbg_val
   );
endinterface
`default_nettype wire

// File: rtl/decode_writeback.sv
`default_nettype none
// ============================================================================
// Module   : decode_writeback
// Purpose  : Decode and write-back stage of the sequential Y86-64 core.
//            Holds the 15-entry architectural register file, decodes the
//            source/destination register IDs and commits valE/valM.
// Revision : 1.0 - initial release
// ============================================================================
module decode_writeback #(
   parameter logic [63:0] RSP_INIT = 64'h0
) (
   input  wire logic            clk,
   input  wire logic            rst,
   decode_writeback_if.slave    bus
);

   localparam logic [3:0] c_CMOVXX = 4'h2;
   localparam logic [3:0] c_IRMOVQ = 4'h3;
   localparam logic [3:0] c_RMMOVQ = 4'h4;
   localparam logic [3:0] c_MRMOVQ = 4'h5;
   localparam logic [3:0] c_OPQ    = 4'h6;
   localparam logic [3:0] c_CALL   = 4'h8;
   localparam logic [3:0] c_RET    = 4'h9;
   localparam logic [3:0] c_PUSHQ  = 4'hA;
   localparam logic [3:0] c_POPQ   = 4'hB;
   localparam logic [3:0] c_RNONE  = 4'hF;
   localparam logic [3:0] c_RSP    = 4'h4;

   // IDs 0..14 have storage; ID 15 (RNONE) is handled by the read/write guards.
   logic [63:0] r_regs [0:14];

   logic [3:0] w_srcA;
   logic [3:0] w_srcB;
   logic [3:0] w_dstE;
   logic [3:0] w_dstM;

   // Register ID decode from icode/rA/rB; unknown icodes fall to RNONE.
   always_comb begin
      w_srcA = c_RNONE;
      w_srcB = c_RNONE;
      w_dstE = c_RNONE;
      w_dstM = c_RNONE;
      case (bus.icode)
         c_CMOVXX: begin
            w_srcA = bus.rA;
            w_dstE = bus.cnd ? bus.rB : c_RNONE;
         end
         c_IRMOVQ: begin
            w_dstE = bus.rB;
         end
         c_RMMOVQ: begin
            w_srcA = bus.rA;
            w_srcB = bus.rB;
         end
         c_MRMOVQ: begin
            w_srcB = bus.rB;
            w_dstM = bus.rA;
         end
         c_OPQ: begin
            w_srcA = bus.rA;
            w_srcB = bus.rB;
            w_dstE = bus.rB;
         end
         c_CALL: begin
            w_srcB = c_RSP;
            w_dstE = c_RSP;
         end
         c_RET: begin
            w_srcA = c_RSP;
            w_srcB = c_RSP;
            w_dstE = c_RSP;
         end
         c_PUSHQ: begin
            w_srcA = bus.rA;
            w_srcB = c_RSP;
            w_dstE = c_RSP;
         end
         c_POPQ: begin
            w_srcA = c_RSP;
            w_srcB = c_RSP;
            w_dstE = c_RSP;
            w_dstM = bus.rA;
         end
         default: begin
         end
      endcase
   end

   // Register file: async reset to RSP_INIT/0; the valM write is issued last
   // so it overrides valE when both target the same register (popq %rsp).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 15; i++) begin
            r_regs[i] <= (i == 4) ? RSP_INIT : 64'h0;
         end
      end else if (!bus.halt) begin
         if (w_dstE != c_RNONE) r_regs[w_dstE] <= bus.valE;
         if (w_dstM != c_RNONE) r_regs[w_dstM] <= bus.valM;
      end
   end

   // Combinational read ports; RNONE reads as zero and there is no bypass.
   always_comb begin
      bus.valA    = (w_srcA      == c_RNONE) ? 64'h0 : r_regs[w_srcA];
      bus.valB    = (w_srcB      == c_RNONE) ? 64'h0 : r_regs[w_srcB];
      bus.dbg_val = (bus.dbg_sel == c_RNONE) ? 64'h0 : r_regs[bus.dbg_sel];
   end

   assign bus.srcA   = w_srcA;
   assign bus.srcB   = w_srcB;
   assign bus.dstE   = w_dstE;
   assign bus.dstM   = w_dstM;
   assign bus.ifun_o = bus.ifun;

endmodule
`default_nettype wire

// File: tb/tb_decode_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_writeback
// Purpose  : Directed self-checking bench for decode_writeback: a decode
//            vector table plus hand-written write-back / reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_writeback;

   localparam logic [63:0] c_RSP_INIT = 64'h100;

   logic clk;
   logic rst;

   decode_writeback_if bus ();

   decode_writeback #(.RSP_INIT(c_RSP_INIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   // One comparison; prints a FAIL line on mismatch.
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Let one rising edge pass, return at the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic dbg_chk(input string name, input logic [3:0] sel, input logic [63:0] exp);
      bus.dbg_sel = sel;
      #1;
      chk(name, bus.dbg_val, exp);
   endtask

   task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] ve, input logic [63:0] vm);
      bus.icode = ic;
      bus.rA    = ra;
      bus.rB    = rb;
      bus.valE  = ve;
      bus.valM  = vm;
   endtask

   typedef struct {
      logic [3:0] icode;
      logic [3:0] ifun;
      logic       cnd;
      logic [3:0] e_srcA;
      logic [3:0] e_srcB;
      logic [3:0] e_dstE;
      logic [3:0] e_dstM;
   } dec_vec_t;

   dec_vec_t vecs [18];

   initial begin
      n_vec = 0;
      n_err = 0;

      // Decode table with rA=1, rB=2.
      vecs[0]  = '{4'h0, 4'h0, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
      vecs[1]  = '{4'h1, 4'h1, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
      vecs[2]  = '{4'h2, 4'h3, 1'b1, 4'h1, 4'hF, 4'h2, 4'hF};
      vecs[3]  = '{4'h2, 4'h3, 1'b0, 4'h1, 4'hF, 4'hF, 4'hF};
      vecs[4]  = '{4'h3, 4'h0, 1'b0, 4'hF, 4'hF, 4'h2, 4'hF};
      vecs[5]  = '{4'h4, 4'h0, 1'b0, 4'h1, 4'h2, 4'hF, 4'hF};
      vecs[6]  = '{4'h5, 4'h0, 1'b0, 4'hF, 4'h2, 4'hF, 4'h1};
      vecs[7]  = '{4'h6, 4'h5, 1'b0, 4'h1, 4'h2, 4'h2, 4'hF};
      vecs[8]  = '{4'h7, 4'h4, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
      vecs[9]  = '{4'h8, 4'h0, 1'b0, 4'hF, 4'h4, 4'h4, 4'hF};
      vecs[10] = '{4'h9, 4'h0, 1'b0, 4'h4, 4'h4, 4'h4, 4'hF};
      vecs[11] = '{4'hA, 4'h0, 1'b0, 4'h1, 4'h4, 4'h4, 4'hF};
      vecs[12] = '{4'hB, 4'h0, 1'b0, 4'h4, 4'h4, 4'h4, 4'h1};
      vecs[13] = '{4'hC, 4'h7, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
      vecs[14] = '{4'hD, 4'h0, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
      vecs[15] = '{4'hE, 4'h0, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
      vecs[16] = '{4'hF, 4'h9, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
      vecs[17] = '{4'h6, 4'hF, 1'b1, 4'h1, 4'h2, 4'h2, 4'hF};

      rst         = 1'b1;
      bus.icode   = 4'h1;
      bus.ifun    = 4'h0;
      bus.rA      = 4'hF;
      bus.rB      = 4'hF;
      bus.cnd     = 1'b0;
      bus.valE    = 64'h0;
      bus.valM    = 64'h0;
      bus.halt    = 1'b0;
      bus.dbg_sel = 4'h0;

      // Reset contents: only %rsp holds RSP_INIT; RNONE reads zero.
      repeat (2) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         dbg_chk($sformatf("reset_r%0d", i), 4'(i), (i == 4) ? c_RSP_INIT : 64'h0);
      end
      rst = 1'b0;

      // Decode table, writes suppressed by halt.
      bus.halt = 1'b1;
      bus.rA   = 4'h1;
      bus.rB   = 4'h2;
      for (int v = 0; v < 18; v++) begin
         bus.icode = vecs[v].icode;
         bus.ifun  = vecs[v].ifun;
         bus.cnd   = vecs[v].cnd;
         #1;
         chk($sformatf("decode_v%0d", v),
             {44'h0, bus.srcA, bus.srcB, bus.dstE, bus.dstM, bus.ifun_o},
             {44'h0, vecs[v].e_srcA, vecs[v].e_srcB, vecs[v].e_dstE, vecs[v].e_dstM, vecs[v].ifun});
      end
      step();
      dbg_chk("halt_table_r2", 4'h2, 64'h0);
      bus.halt = 1'b0;
      bus.cnd  = 1'b0;

      // irmovq -> reg 2, then OPq reading it.
      drive(4'h3, 4'hF, 4'h2, 64'h1234, 64'h0);
      #1;
      chk("irmovq_srcA", {60'h0, bus.srcA}, 64'hF);
      chk("irmovq_srcB", {60'h0, bus.srcB}, 64'hF);
      chk("irmovq_dstE", {60'h0, bus.dstE}, 64'h2);
      step();
      drive(4'h6, 4'h2, 4'h3, 64'h1234, 64'h0);
      #1;
      chk("opq_valA", bus.valA, 64'h1234);
      chk("opq_valB", bus.valB, 64'h0);
      chk("opq_dstE", {60'h0, bus.dstE}, 64'h3);
      step();
      dbg_chk("opq_r3", 4'h3, 64'h1234);

      // popq %rsp: valM must win over valE.
      drive(4'hB, 4'h4, 4'hF, 64'h108, 64'hDEAD);
      #1;
      chk("popq_dstE", {60'h0, bus.dstE}, 64'h4);
      chk("popq_dstM", {60'h0, bus.dstM}, 64'h4);
      step();
      dbg_chk("popq_rsp", 4'h4, 64'hDEAD);

      // cmovXX with cnd=0 then cnd=1.
      drive(4'h2, 4'h1, 4'h5, 64'h55, 64'h0);
      bus.cnd = 1'b0;
      #1;
      chk("cmov_nc_dstE", {60'h0, bus.dstE}, 64'hF);
      step();
      dbg_chk("cmov_nc_r5", 4'h5, 64'h0);
      bus.cnd = 1'b1;
      #1;
      chk("cmov_c_dstE", {60'h0, bus.dstE}, 64'h5);
      step();
      dbg_chk("cmov_c_r5", 4'h5, 64'h55);
      bus.cnd = 1'b0;

      // halt suppresses the write; it lands once halt drops.
      drive(4'h3, 4'hF, 4'h7, 64'h77, 64'h0);
      bus.halt = 1'b1;
      step();
      dbg_chk("halt_r7", 4'h7, 64'h0);
      bus.halt = 1'b0;
      step();
      dbg_chk("unhalt_r7", 4'h7, 64'h77);

      // Same-cycle read/write: old value during the cycle, new after.
      drive(4'h3, 4'hF, 4'h3, 64'h5, 64'h0);
      step();
      drive(4'h6, 4'h3, 4'h3, 64'h9, 64'h0);
      #1;
      chk("rw_same_valA", bus.valA, 64'h5);
      chk("rw_same_valB", bus.valB, 64'h5);
      step();
      chk("rw_next_valA", bus.valA, 64'h9);
      chk("rw_next_valB", bus.valB, 64'h9);

      // Asynchronous reset pulse between edges.
      drive(4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
      drive(4'h6, 4'h3, 4'h7, 64'h0, 64'h0);
      bus.halt = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      chk("arst_valA", bus.valA, 64'h0);
      chk("arst_valB", bus.valB, 64'h0);
      chk("arst_srcA", {60'h0, bus.srcA}, 64'h3);
      dbg_chk("arst_r4", 4'h4, c_RSP_INIT);
      rst = 1'b0;
      bus.halt = 1'b0;
      bus.icode = 4'h1;
      #1;
      dbg_chk("arst_r5", 4'h5, 64'h0);
      dbg_chk("arst_r2", 4'h2, 64'h0);

      // First write after reset release lands on the next edge.
      drive(4'h3, 4'hF, 4'hE, 64'hABCD, 64'h0);
      step();
      dbg_chk("post_rst_r14", 4'hE, 64'hABCD);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/decode_writeback.md
# decode_writeback

Decode and write-back stage of the sequential Y86-64 processor, holding the 15-entry architectural register file. It sits directly downstream of fetch: it takes `icode`, `ifun`, `rA` and `rB` and produces operands `valA`/`valB` for execute. It also takes `valE`/`valM` back from execute/memory and commits them to the register file at the end of the instruction's cycle.

## Interface
Parameters:
- `RSP_INIT`, 64'h0, value loaded into %rsp (reg 4) on reset; all other registers reset to 0.

Ports:
- `clk`  in  1  clock; all register writes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `icode`  in  4  instruction code from fetch.
- `ifun`  in  4  function code from fetch (unused except pass-through `ifun_o`).
- `rA`  in  4  register specifier A from fetch; 4'hF = RNONE.
- `rB`  in  4  register specifier B from fetch; 4'hF = RNONE.
- `cnd`  in  1  condition result from execute, qualifies cmovXX write.
- `valE`  in  64  ALU result from execute.
- `valM`  in  64  data read from memory stage.
- `halt`  in  1  processor status is not AOK; suppresses all writes.
- `dbg_sel`  in  4  debug read-port register select.
- `valA`  out  64  operand A = R[srcA], 0 if srcA = RNONE.
- `valB`  out  64  operand B = R[srcB], 0 if srcB = RNONE.
- `srcA`, `srcB`, `dstE`, `dstM`  out  4 each  decoded register IDs.
- `ifun_o`  out  4  `ifun` passed through.
- `dbg_val`  out  64  R[dbg_sel], 0 for 4'hF.

## Operation
- Register file: 15 × 64-bit registers, IDs 0–14 (rax…r14, rsp = 4). ID 15 is RNONE, with no storage. Reads of RNONE return 0; writes to RNONE are dropped.
- Source decode (combinational):
  - srcA = rA for cmovXX(2), rmmovq(4), OPq(6), pushq(A).
  - srcA = 4 for popq(B), ret(9).
  - srcA = F otherwise.
- srcB decode:
  - srcB = rB for rmmovq, mrmovq(5), OPq.
  - srcB = 4 for pushq, popq, call(8), ret.
  - srcB = F otherwise.
- Destination decode:
  - dstE = rB for irmovq(3) and OPq.
  - dstE = rB for cmovXX only when cnd=1; F when cnd=0.
  - dstE = 4 for pushq, popq, call, ret.
  - dstE = F otherwise.
  - dstM = rA for mrmovq, popq; F otherwise.
- Invalid icode (C–F) and halt/nop/jXX: all four IDs = F.
- Write-back, on rising `clk` when `halt`=0:
  - R[dstE] ← valE if dstE≠F.
  - R[dstM] ← valM if dstM≠F.
  - If dstE = dstM ≠ F (popq %rsp), valM wins; R[4] ← valM.
- `halt`=1: no register changes; reads still operate.

## Timing
- Reads and ID decode are combinational: zero-cycle latency from `icode`/`rA`/`rB` to `valA`/`valB`.
- Writes become visible on reads in the cycle after the capturing edge. A read in the same cycle as a write to the same register returns the old value; there is no write-to-read bypass.
- `rst` assertion, asynchronous and mid-cycle included:
  - All registers clear immediately, and R[4] takes `RSP_INIT`.
  - Outputs then reflect reset contents: valA/valB/dbg_val = 0, except reads of reg 4 = RSP_INIT.
  - Decoded IDs follow inputs.
- While `rst`=1, no writes occur. The first write is possible on the first rising edge after deassertion.
- A write in progress when `rst` asserts is discarded.

## Test plan
- Reset with RSP_INIT=64'h100 → dbg_sel sweep 0–14: reg 4 = 0x100, all others 0; dbg_sel=F → 0.
- irmovq (icode 3, rA=F, rB=2), valE=64'h1234, then OPq addq (icode 6, rA=2, rB=3) next cycle:
  - First cycle: srcA=srcB=F, dstE=2.
  - After the edge: valA=0x1234, valB=0, dstE=3.
- popq %rsp (icode B, rA=4) with valE=0x108, valM=0xDEAD → after edge R[4]=0xDEAD, not 0x108.
- cmovXX (icode 2, rA=1, rB=5), valE=0x55:
  - cnd=0 → dstE=F, R[5] unchanged.
  - cnd=1 → R[5]=0x55 after edge.
- halt=1 with irmovq to reg 7, valE=0x77 → R[7] stays 0; deassert halt → write lands next edge.
- Same-cycle read/write: OPq with rA=rB=3, R[3]=5, valE=9 → valA=valB=5 during the cycle, 9 the cycle after.
- Async `rst` pulse between edges after several writes → all registers return to reset values immediately, without a clock edge.
